// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and constants for the LIF layer scheduler
package neuron_pkg;

    typedef logic [15:0] membrane_t;
    typedef logic [7:0]  leak_t;

    localparam membrane_t RESET_VAL = 16'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } lif_sched_state_e;

endpackage

// File: rtl/lif_update_unit.sv
// rtl/lif_update_unit.sv - combinational LIF update for one neuron
module lif_update_unit
    import neuron_pkg::*;
(
    input  logic [15:0] potential,
    input  logic        spike,
    input  logic [15:0] threshold,
    input  logic [7:0]  leak,
    output logic [15:0] next_potential,
    output logic        fire
);

    logic [16:0] w_sum;
    logic [15:0] w_sat;
    logic [15:0] w_leak;
    logic [15:0] w_leaked;

    assign fire = (potential >= threshold);

    // Spike contribution is a quarter of threshold; carry out means saturate.
    assign w_sum    = {1'b0, potential} + (spike ? {3'b000, threshold[15:2]} : 17'd0);
    assign w_sat    = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    assign w_leak   = {8'd0, leak};
    assign w_leaked = (w_sat < w_leak) ? 16'd0 : (w_sat - w_leak);

    assign next_potential = fire ? RESET_VAL : w_leaked;

endmodule

// File: rtl/lif_layer_scheduler.sv
// rtl/lif_layer_scheduler.sv - time-multiplexed LIF layer with AER event output
module lif_layer_scheduler
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int ID_W        = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_start,
    input  logic [NUM_NEURONS-1:0] in_spikes,
    input  logic [7:0]             leak_factor,
    input  logic [15:0]            threshold,
    input  logic                   clear_state,
    output logic                   busy,
    output logic                   step_done,
    output logic [NUM_NEURONS-1:0] out_spikes,
    output logic                   ev_valid,
    output logic [ID_W-1:0]        ev_id,
    input  logic                   ev_ready
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_NEURONS - 1);

    lif_sched_state_e       r_state;
    lif_sched_state_e       w_state_nxt;
    logic [ID_W-1:0]        r_idx;
    logic [NUM_NEURONS-1:0] r_spk_lat;
    logic [NUM_NEURONS-1:0] r_acc;
    logic [NUM_NEURONS-1:0] r_out_spikes;
    logic                   r_ev_valid;
    logic [ID_W-1:0]        r_ev_id;
    membrane_t              r_pot [NUM_NEURONS];

    logic [15:0] w_next_pot;
    logic        w_fire;
    logic        w_updating;
    logic        w_stall;
    logic        w_commit;

    lif_update_unit u_update (
        .potential      (r_pot[r_idx]),
        .spike          (r_spk_lat[r_idx]),
        .threshold      (threshold),
        .leak           (leak_factor),
        .next_potential (w_next_pot),
        .fire           (w_fire)
    );

    // A firing neuron may only commit if the event slot is free this cycle.
    assign w_updating = (r_state == ST_UPDATE);
    assign w_stall    = w_updating && w_fire && r_ev_valid && !ev_ready;
    assign w_commit   = w_updating && !w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (step_start) w_state_nxt = ST_UPDATE;
            ST_UPDATE: if (w_commit && (r_idx == LAST_IDX)) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_spk_lat    <= '0;
            r_acc        <= '0;
            r_out_spikes <= '0;
            r_ev_valid   <= 1'b0;
            r_ev_id      <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_pot[i] <= RESET_VAL;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (step_start) begin
                        r_spk_lat <= in_spikes;
                        r_acc     <= '0;
                        r_idx     <= '0;
                    end else if (clear_state) begin
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            r_pot[i] <= RESET_VAL;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (w_commit) begin
                        r_pot[r_idx] <= w_next_pot;
                        if (w_fire) r_acc[r_idx] <= 1'b1;
                        if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: r_out_spikes <= r_acc;
                default: ;
            endcase

            // A newly committed event overwrites one being accepted this cycle.
            if (w_commit && w_fire) begin
                r_ev_valid <= 1'b1;
                r_ev_id    <= r_idx;
            end else if (r_ev_valid && ev_ready) begin
                r_ev_valid <= 1'b0;
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign step_done  = (r_state == ST_DONE);
    assign out_spikes = r_out_spikes;
    assign ev_valid   = r_ev_valid;
    assign ev_id      = r_ev_id;

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// tb/tb_lif_layer_scheduler.sv - self-checking bench for lif_layer_scheduler
module tb_lif_layer_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         step_start = 1'b0;
    logic [N-1:0] in_spikes = '0;
    logic [7:0]   leak_factor = 8'd0;
    logic [15:0]  threshold = 16'd0;
    logic         clear_state = 1'b0;
    logic         busy;
    logic         step_done;
    logic [N-1:0] out_spikes;
    logic         ev_valid;
    logic [1:0]   ev_id;
    logic         ev_ready = 1'b1;

    lif_layer_scheduler #(.NUM_NEURONS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .step_start  (step_start),
        .in_spikes   (in_spikes),
        .leak_factor (leak_factor),
        .threshold   (threshold),
        .clear_state (clear_state),
        .busy        (busy),
        .step_done   (step_done),
        .out_spikes  (out_spikes),
        .ev_valid    (ev_valid),
        .ev_id       (ev_id),
        .ev_ready    (ev_ready)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int unsigned mpot [N];
    logic [N-1:0] exp_out;
    int          exp_q [$];
    int          rcv_q [$];
    bit          rand_ready = 1'b0;
    int          done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: one whole timestep as plain integer arithmetic.
    task automatic model_step(input logic [N-1:0] spk);
        int unsigned s;
        exp_out = '0;
        for (int i = 0; i < N; i++) begin
            if (mpot[i] >= threshold) begin
                mpot[i] = 0;
                exp_out[i] = 1'b1;
                exp_q.push_back(i);
            end else begin
                s = mpot[i] + (spk[i] ? threshold / 4 : 0);
                if (s > 65535) s = 65535;
                mpot[i] = (s > leak_factor) ? s - leak_factor : 0;
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) mpot[i] = 0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_state = 1'b1;
        @(posedge clk);
        #1 clear_state = 1'b0;
        model_clear();
    endtask

    task automatic compare_events();
        chk("ev_count", rcv_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rcv_q.size() > 0) begin
            chk("ev_id_order", rcv_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        rcv_q.delete();
    endtask

    task automatic run_step(input logic [N-1:0] spk, input int hold, input bit hold_start);
        bit         prev_pend;
        logic [1:0] prev_id;
        int         extra;
        prev_pend = 1'b0;
        prev_id = '0;
        @(negedge clk);
        step_start = 1'b1;
        in_spikes = spk;
        @(posedge clk);
        #1 step_start = hold_start;
        model_step(spk);
        done_cyc = -1;
        for (int k = 1; k <= 200 && done_cyc < 0; k++) begin
            @(negedge clk);
            ev_ready = (k <= hold) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            #1;
            if (!busy) chk("busy_in_step", busy, 1'b1);
            if (prev_pend) begin
                chk("ev_hold_valid", ev_valid, 1'b1);
                chk("ev_hold_id", ev_id, prev_id);
            end
            if (ev_valid && ev_ready) rcv_q.push_back(int'(ev_id));
            prev_pend = ev_valid && !ev_ready;
            prev_id = ev_id;
            if (step_done) done_cyc = k;
        end
        if (done_cyc < 0) chk("step_timeout", 32'd0, 32'd1);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            step_start = 1'b0;
            ev_ready = 1'b1;
            #1;
            if (step_done) extra++;
            if (ev_valid) rcv_q.push_back(int'(ev_id));
            else if (k >= 2) break;
        end
        chk("no_extra_done", extra, 0);
        chk("idle_after", busy, 1'b0);
        chk("out_spikes", out_spikes, exp_out);
        compare_events();
        for (int i = 0; i < N; i++) chk($sformatf("pot%0d", i), dut.r_pot[i], mpot[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned exp_p0 [6] = '{20, 40, 60, 80, 100, 0};
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_step_done", step_done, 1'b0);
        chk("rst_out_spikes", out_spikes, '0);
        chk("rst_ev_valid", ev_valid, 1'b0);
        chk("rst_ev_id", ev_id, '0);
        @(negedge clk);
        rst = 1'b0;

        // integration ramp of neuron 0
        threshold = 16'd100;
        leak_factor = 8'd5;
        for (int s = 0; s < 6; s++) begin
            run_step(4'b0001, 0, 1'b0);
            chk("latency", done_cyc, 5);
            chk("int_pot0", dut.r_pot[0], exp_p0[s]);
        end
        chk("int_out6", out_spikes, 4'b0001);

        // quiet step latency
        run_step(4'b0000, 0, 1'b0);
        chk("quiet_latency", done_cyc, 5);

        // clear_state restarts integration from zero
        run_step(4'b0001, 0, 1'b0);
        do_clear();
        run_step(4'b0001, 0, 1'b0);
        chk("clear_pot0", dut.r_pot[0], 32'd20);

        // step_start held through the whole step yields one step only
        run_step(4'b0000, 0, 1'b1);
        chk("busy_ignore_latency", done_cyc, 5);

        // backpressure: all four fire, slot blocked for ten cycles
        do_clear();
        leak_factor = 8'd0;
        repeat (4) run_step(4'b1111, 0, 1'b0);
        run_step(4'b0000, 10, 1'b0);
        chk("bp_latency", done_cyc, 14);
        chk("bp_out", out_spikes, 4'b1111);

        // reset in the middle of a step with an event pending
        do_clear();
        repeat (4) run_step(4'b1111, 0, 1'b0);
        @(negedge clk);
        step_start = 1'b1;
        in_spikes = 4'b0000;
        ev_ready = 1'b0;
        @(posedge clk);
        #1 step_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_ev_valid", ev_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", step_done, 1'b0);
        chk("mid_rst_out", out_spikes, '0);
        chk("mid_rst_ev_valid", ev_valid, 1'b0);
        chk("mid_rst_ev_id", ev_id, '0);
        chk("mid_rst_pot2", dut.r_pot[2], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ev_ready = 1'b1;
        model_clear();
        exp_q.delete();
        rcv_q.delete();
        leak_factor = 8'd5;
        run_step(4'b0001, 0, 1'b0);
        chk("post_rst_pot0", dut.r_pot[0], 32'd20);

        // saturation at 0xFFFF then fire
        do_clear();
        threshold = 16'hFFFF;
        leak_factor = 8'd0;
        repeat (5) run_step(4'b0001, 0, 1'b0);
        chk("sat_pot0", dut.r_pot[0], 32'hFFFF);
        run_step(4'b0001, 0, 1'b0);
        chk("sat_fire_pot0", dut.r_pot[0], 32'd0);
        chk("sat_fire_out", out_spikes, 4'b0001);

        // threshold zero: everyone fires
        threshold = 16'd0;
        run_step(4'b1010, 0, 1'b0);
        chk("thr0_out", out_spikes, 4'b1111);

        // randomized steps with random backpressure
        do_clear();
        rand_ready = 1'b1;
        for (int s = 0; s < 30; s++) begin
            threshold = 16'($urandom_range(0, 400));
            leak_factor = 8'($urandom_range(0, 40));
            run_step(4'($urandom), 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lif_layer_scheduler.md
Name: lif_layer_scheduler

Overview:
- Time-multiplexed controller for a layer of NUM_NEURONS LIF neurons.
- Shares one LIF update datapath across all neurons and holds each neuron's membrane potential in an internal register array.
- On each timestep it evaluates neurons 0..NUM_NEURONS-1 in order, then emits fired-neuron IDs as an address-event (AER) stream with valid/ready backpressure.
- Sits between the input spike fabric (per-timestep spike vector) and the downstream spike router.

Parameters:
- NUM_NEURONS, 16, neurons in the layer; ≥2.
- ID_W, $clog2(NUM_NEURONS), width of neuron index / event ID.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- step_start  input  1  pulse requesting one timestep; honoured only in IDLE.
- in_spikes  input  NUM_NEURONS  input spike per neuron; sampled on the cycle step_start is accepted.
- leak_factor  input  leak_t  leak subtracted per evaluation.
- threshold  input  16  firing threshold.
- clear_state  input  1  resets all potentials to RESET_VAL; honoured only in IDLE.
- busy  output  1  high outside IDLE.
- step_done  output  1  one-cycle pulse at end of timestep.
- out_spikes  output  NUM_NEURONS  fired vector of last completed timestep.
- ev_valid  output  1  spike event available.
- ev_id  output  ID_W  index of fired neuron.
- ev_ready  input  1  downstream accepts event.

Behaviour:
Interface:
- One clock; reset is asynchronous and active-high.
- Reset values: busy=0, step_done=0, out_spikes=0, ev_valid=0, ev_id=0, all potentials=RESET_VAL, idx=0, state=IDLE.

FSM states: IDLE, UPDATE, DONE.
- IDLE:
  - step_start=1: latch in_spikes into spk_lat, clear the fired-vector accumulator, set idx=0, go to UPDATE.
  - clear_state=1 with step_start=0: all potentials become RESET_VAL next cycle.
  - clear_state=1 with step_start=1: step_start wins; clear_state is ignored.
- UPDATE, neuron idx:
  - Fire condition: pot[idx] >= threshold.
  - On fire: pot[idx] <= RESET_VAL, set acc[idx]=1, load the event register with ev_id=idx, ev_valid=1.
  - On no fire: pot[idx] <= sat(pot[idx] + (spk_lat[idx] ? threshold>>2 : 0) − leak_factor).
  - Stall: if the neuron fires while the event slot is occupied (ev_valid=1 and ev_ready=0), nothing commits. pot, acc and idx all hold; re-evaluate next cycle.
  - If ev_ready=1 in the same cycle, the slot is free and the new event overwrites the accepted one.
  - Non-firing neurons never stall.
  - After committing idx=NUM_NEURONS−1, go to DONE; otherwise idx++.
- DONE (1 cycle):
  - step_done=1, out_spikes<=acc, go to IDLE.
  - step_start in DONE is ignored.
- Latency: with no stalls, step_start accepted in cycle 0 gives UPDATE in cycles 1..N and step_done visible in cycle N+1.
- Event handshake:
  - Transfer occurs when ev_valid && ev_ready; ev_valid drops the next cycle unless reloaded.
  - ev_id is stable while ev_valid=1 and ev_ready=0.
  - An event still pending at DONE stays pending into the next step.
- Arithmetic:
  - The add is computed 17 bits wide; a result above 0xFFFF saturates to 0xFFFF.
  - Subtracting leak below 0 clamps to 0.
  - threshold>>2 is a logical shift; threshold=0 makes every neuron fire every step.
  - threshold and leak_factor are sampled live each UPDATE cycle and must be held stable by the system during a step.
- Reset mid-step: everything returns to reset values, and any pending event is dropped.

Decomposition:
- Shared package (neuron_pkg):
  - membrane_t (16-bit unsigned), leak_t (8-bit unsigned), RESET_VAL (0).
  - lif_sched_state_e enum for the FSM states.
- Sub-module: lif_update_unit, combinational. Inputs: potential, spike, threshold, leak. Outputs: next_potential, fire. Contains the saturation logic.
- The FSM, index counter, potential array and event register stay in lif_layer_scheduler.

Test Plan:
- Integration run: NUM_NEURONS=4, threshold=100, leak=5, in_spikes=4'b0001 every step, ev_ready=1.
  - pot[0] follows 20, 40, 60, 80, 100.
  - Step 6 emits ev_id=0, pot[0]=0, out_spikes=4'b0001.
  - Neurons 1–3 clamp at 0.
- Latency: a single step with no firing gives step_done exactly 5 cycles after the step_start cycle, and busy=1 for cycles 1..5.
- Backpressure:
  - Preload all pots to ≥100 via repeated steps, hold ev_ready=0.
  - Neuron 0 event is loaded; neuron 1 stalls and idx holds.
  - Release ev_ready: IDs 0, 1, 2, 3 arrive in order with no loss, and step_done follows the last commit.
- Saturation: threshold=0xFFFF, leak=0, spike every step → pot saturates at 0xFFFF, then fires and resets to 0.
- Control edge cases:
  - step_start while busy is ignored: exactly one step_done.
  - clear_state in IDLE zeroes pots: the next step gives pot[0]=20 in the integration setup.
- Reset mid-step: assert rst during UPDATE with ev_valid=1.
  - All outputs immediately return to 0.
  - The next step behaves as if from power-up.
